// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory port controller.
// Runs one valid/grant/response bus transaction per load or store. It stalls
// the pipeline until the access completes and returns the raw 32-bit bus word.
// Optional feature macro: DMEM_TIMEOUT_EN. When it is defined, an access stuck
// in REQ/WAIT is forced to complete with mem_err_o after TIMEOUT_CYCLES cycles.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    input  logic        flush_i,
    input  logic        pipe_hold_i,
    output logic        mem_stall_o,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic        w_unused_addr_lsb;

    // Byte offset is resolved by the load/store formatters; the bus is word-addressed.
    assign w_unused_addr_lsb = ^mem_addr_i[1:0];

    // A new access is taken only from IDLE, and only if it is not being killed.
    assign w_accept = (r_state == S_IDLE) && mem_valid_i && !flush_i;

    assign bus_we_o    = r_we;
    assign bus_addr_o  = {r_addr, 2'b00};
    assign bus_wdata_o = r_wdata;
    assign bus_wstrb_o = r_wstrb;
    assign mem_rdata_o = r_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Flush beats a response that arrives in the same cycle,
    // and a grant beats a timeout because the slave has then committed to the access.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mem_valid_i && !flush_i) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (flush_i) begin
                    if (bus_gnt_i && !bus_rvalid_i) w_state_next = S_DRAIN;
                    else                            w_state_next = S_IDLE;
                end else if (bus_gnt_i && bus_rvalid_i) begin
                    w_state_next = S_DONE;
                    w_capture    = 1'b1;
                end else if (bus_gnt_i) begin
                    w_state_next = S_WAIT;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_state_next = bus_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (bus_rvalid_i) begin
                    w_state_next = S_DONE;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DRAIN: begin
                if (bus_rvalid_i || w_timeout) w_state_next = S_IDLE;
            end
            S_DONE: begin
                if (flush_i || !pipe_hold_i) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode. The IDLE stall is combinational so the pipeline freezes in the request cycle.
    always_comb begin
        bus_req_o   = 1'b0;
        mem_stall_o = 1'b0;
        mem_done_o  = 1'b0;
        unique case (r_state)
            S_IDLE:  mem_stall_o = mem_valid_i && !flush_i;
            S_REQ: begin
                bus_req_o   = 1'b1;
                mem_stall_o = 1'b1;
            end
            S_WAIT:  mem_stall_o = 1'b1;
            S_DRAIN: mem_stall_o = 1'b1;
            S_DONE:  mem_done_o  = 1'b1;
            default: ;
        endcase
    end

    // Request latch and response capture. Loads carry no strobes and stores return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i[31:2];
            r_wdata <= mem_wdata_i;
            r_wstrb <= mem_we_i ? mem_wstrb_i : 4'b0000;
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= r_we ? 32'h0 : bus_rdata_i;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : ((CNT_W_RAW > 16) ? 16 : CNT_W_RAW);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    // The count starts at 0 in the first REQ cycle, so expiry lands after TIMEOUT_CYCLES cycles.
    assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DRAIN))
                       && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_err_o = r_err && (r_state == S_DONE);

    // Timeout counter. It is cleared when a request is accepted and runs while bus activity is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DRAIN)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Error flag. It is set when DONE is entered without a captured response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (((r_state == S_REQ) || (r_state == S_WAIT))
                     && (w_state_next == S_DONE) && !w_capture) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_tmo_param;

    // Without the timeout feature the controller waits for the bus indefinitely.
    assign w_timeout          = 1'b0;
    assign mem_err_o          = 1'b0;
    assign w_unused_tmo_param = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl.
// Directed scenarios are followed by randomized transactions. Each transaction
// is checked against a transaction-level model of the expected outcome:
// request count, stall length, DONE residency and returned word.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_we_i, flush_i, pipe_hold_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_stall_o, mem_done_o, mem_err_o;
    logic [31:0] mem_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .flush_i(flush_i), .pipe_hold_i(pipe_hold_i),
        .mem_stall_o(mem_stall_o), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .mem_err_o(mem_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid_i  = 1'b0;
        mem_we_i     = 1'b0;
        flush_i      = 1'b0;
        pipe_hold_i  = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws);
        mem_valid_i = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_wstrb_i = ws;
    endtask

    // One complete access. The slave grants after g non-granted REQ cycles and
    // responds r cycles after the grant. The pipeline holds DONE for h extra cycles.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int g, input int r, input int h,
                           input logic [31:0] rd);
        int          req_cnt   = 0;
        int          stall_cnt = 0;
        int          done_cnt  = 0;
        int          gnt_cyc   = -1;
        bit          fin       = 1'b0;
        logic [31:0] exp_rd    = we ? 32'h0 : rd;
        logic [3:0]  exp_ws    = we ? ws : 4'h0;
        logic [31:0] exp_addr  = {addr[31:2], 2'b00};
        @(negedge clk);
        idle_inputs();
        present(we, addr, wd, ws);
        bus_rvalid_i = 1'($urandom_range(0, 1));   // stray response while IDLE
        bus_rdata_i  = $urandom;
        #1;
        check("idle_stall", mem_stall_o, 1);
        check("idle_req", bus_req_o, 0);
        stall_cnt = 1;
        for (int cyc = 1; cyc <= 64 && !fin; cyc++) begin
            @(negedge clk);
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            pipe_hold_i  = 1'b0;
            #1;
            if (bus_req_o) begin
                req_cnt++;
                check("bus_addr", bus_addr_o, exp_addr);
                check("bus_we", bus_we_o, we);
                check("bus_wstrb", bus_wstrb_o, exp_ws);
                if (we) check("bus_wdata", bus_wdata_o, wd);
                if (req_cnt == 1) check("rdata_cleared", mem_rdata_o, 0);
                if (req_cnt == g + 1) begin
                    bus_gnt_i = 1'b1;
                    gnt_cyc   = cyc;
                end
            end
            if (gnt_cyc >= 0 && cyc == gnt_cyc + r) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rd;
            end
            if (mem_done_o) begin
                done_cnt++;
                check("done_rdata", mem_rdata_o, exp_rd);
                check("done_stall", mem_stall_o, 0);
                check("done_err", mem_err_o, 0);
                bus_rvalid_i = 1'b1;               // stray response while DONE
                bus_rdata_i  = $urandom;
                pipe_hold_i  = (done_cnt <= h);
                if (!pipe_hold_i) fin = 1'b1;
            end else if (mem_stall_o) begin
                stall_cnt++;
            end
        end
        check("txn_completed", fin, 1);
        check("req_cycles", req_cnt, g + 1);
        check("stall_cycles", stall_cnt, g + r + 2);
        check("done_cycles", done_cnt, h + 1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post_stall", mem_stall_o, 0);
        check("post_done", mem_done_o, 0);
        check("post_req", bus_req_o, 0);
        n_txn++;
        $display("[TB] txn %0d we=%0d addr=%08h wstrb=%b g=%0d r=%0d h=%0d rdata=%08h stalls=%0d",
                 n_txn, we, addr, ws, g, r, h, mem_rdata_o, stall_cnt);
    endtask

    task automatic flush_after_grant();
        @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_3008, 32'h0, 4'hF); #1;
        @(negedge clk); idle_inputs(); mem_valid_i = 1'b1; #1;
        check("fl_req", bus_req_o, 1);
        bus_gnt_i = 1'b1;
        @(negedge clk); idle_inputs(); mem_valid_i = 1'b1; #1;
        check("fl_wait_stall", mem_stall_o, 1);
        flush_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        check("fl_drain_stall", mem_stall_o, 1);
        check("fl_drain_done", mem_done_o, 0);
        check("fl_drain_req", bus_req_o, 0);
        @(negedge clk); idle_inputs(); #1;
        check("fl_drain2_stall", mem_stall_o, 1);
        check("fl_drain2_done", mem_done_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        @(negedge clk); idle_inputs(); #1;
        check("fl_idle_stall", mem_stall_o, 0);
        check("fl_idle_done", mem_done_o, 0);
        bus_rvalid_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        check("fl_stray_done", mem_done_o, 0);
        check("fl_stray_req", bus_req_o, 0);
        $display("[TB] txn flush-after-grant complete");
    endtask

    task automatic flush_in_req_and_idle();
        @(negedge clk); idle_inputs(); present(1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
        flush_i = 1'b1; #1;
        check("fl_idle_nostall", mem_stall_o, 0);
        @(negedge clk); idle_inputs(); #1;
        check("fl_idle_noreq", bus_req_o, 0);
        @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_5004, 32'h0, 4'h0); #1;
        @(negedge clk); idle_inputs(); mem_valid_i = 1'b1; #1;
        check("flr_req", bus_req_o, 1);
        flush_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        check("flr_dropped_req", bus_req_o, 0);
        check("flr_dropped_stall", mem_stall_o, 0);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        check("flr_idle_done", mem_done_o, 0);
        $display("[TB] txn flush-in-IDLE and flush-in-REQ complete");
    endtask

    task automatic reset_mid_wait();
        @(negedge clk); idle_inputs(); present(1'b1, 32'hA5A5_0010, 32'hCAFE_F00D, 4'b1100); #1;
        @(negedge clk); idle_inputs(); mem_valid_i = 1'b1; #1;
        check("rw_req", bus_req_o, 1);
        bus_gnt_i = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        check("rw_wait_stall", mem_stall_o, 1);
        rst = 1'b1;
        @(negedge clk); idle_inputs(); rst = 1'b0; #1;
        check("rw_req0", bus_req_o, 0);
        check("rw_stall0", mem_stall_o, 0);
        check("rw_done0", mem_done_o, 0);
        check("rw_addr0", bus_addr_o, 0);
        check("rw_wdata0", bus_wdata_o, 0);
        check("rw_wstrb0", bus_wstrb_o, 0);
        check("rw_we0", bus_we_o, 0);
        check("rw_rdata0", mem_rdata_o, 0);
        check("rw_err0", mem_err_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_7777;
        @(negedge clk); idle_inputs(); #1;
        check("rw_late_done", mem_done_o, 0);
        check("rw_late_stall", mem_stall_o, 0);
        check("rw_late_rdata", mem_rdata_o, 0);
        $display("[TB] txn reset-mid-WAIT complete");
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic timeout_case();
        int req_cnt = 0;
        bit seen    = 1'b0;
        @(negedge clk); idle_inputs(); present(1'b0, 32'h0000_6000, 32'h0, 4'h0); #1;
        for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
            @(negedge clk); idle_inputs(); mem_valid_i = 1'b1; #1;
            if (bus_req_o) req_cnt++;
            if (mem_done_o) begin
                seen = 1'b1;
                check("to_err", mem_err_o, 1);
                check("to_rdata", mem_rdata_o, 0);
            end
        end
        check("to_seen", seen, 1);
        check("to_req_cycles", req_cnt, 8);
        @(negedge clk); idle_inputs(); #1;
        check("to_err_cleared", mem_err_o, 0);
        $display("[TB] txn timeout complete req_cycles=%0d", req_cnt);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0; bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", bus_req_o, 0);
        check("rst_stall", mem_stall_o, 0);
        check("rst_done", mem_done_o, 0);
        check("rst_rdata", mem_rdata_o, 0);
        check("rst_err", mem_err_o, 0);
        check("rst_addr", bus_addr_o, 0);
        @(negedge clk); rst = 1'b0;

        run_txn(1'b0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h0000_2001, 32'h0000_AB00, 4'b0010, 3, 2, 0, 32'h5555_AAAA);
        run_txn(1'b0, 32'h0000_1100, 32'h0, 4'h0, 1, 1, 3, 32'h0BAD_F00D);
        flush_after_grant();
        flush_in_req_and_idle();
        reset_mid_wait();
        run_txn(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 0, 1, 0, 32'h8000_0001);
`ifdef DMEM_TIMEOUT_EN
        timeout_case();
`endif
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
